btn_gesture_decoder: RTL and testbench

Classifies activity on one push-button into discrete gesture events: single, double, triple and quadruple short presses, long press and extra-long press. It sits between the raw Basys3 button pin and the timer control FSM. The control FSM consumes one-cycle event pulses instead of timing button edges itself. All thresholds are parameters, so simulation uses short cycle counts and the board build uses millisecond-scale counts.

---
 rtl/btn_gesture_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/btn_gesture_decoder.sv | 136 +++++++++++++
 tb/tb_btn_gesture_decoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_gesture_pkg.sv
// ---------------------------------------------------------------------------
// btn_gesture_pkg
// Shared definitions for the push-button gesture decoder and the timer
// control FSM that consumes its events.
//   - EVT_* : gesture event codes carried on evt_code
//   - gesture_state_t : decoder FSM state encoding
//   - multi_code() : maps the accumulated short-press count to an event code
// ---------------------------------------------------------------------------
package btn_gesture_pkg;

    localparam logic [2:0] EVT_NONE   = 3'd0;
    localparam logic [2:0] EVT_SHORT  = 3'd1;
    localparam logic [2:0] EVT_DOUBLE = 3'd2;
    localparam logic [2:0] EVT_TRIPLE = 3'd3;
    localparam logic [2:0] EVT_QUAD   = 3'd4;
    localparam logic [2:0] EVT_LONG   = 3'd5;
    localparam logic [2:0] EVT_XLONG  = 3'd6;
    localparam logic [2:0] EVT_OVER   = 3'd7;

    // Short-press counter saturates here; five or more presses report OVER.
    localparam logic [2:0] N_SHORT_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_REL = 2'd3
    } gesture_state_t;

    function automatic logic [2:0] multi_code(input logic [2:0] n_short);
        return (n_short >= N_SHORT_MAX) ? EVT_OVER : n_short;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a consecutive-sample filter. The
// debounced level follows the synchronized input only after DEB_CYC
// consecutive samples disagree with the current debounced level.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (output clears to released)
//   i_btn  in  raw asynchronous button level, 1 = pressed
//   o_db   out debounced button level
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_gesture_pkg::*;
#(
    parameter int DEB_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_db
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any sample that agrees with r_db restarts the run.
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/btn_gesture_decoder.sv
// ---------------------------------------------------------------------------
// btn_gesture_decoder
// Classifies one push-button into gesture events (1..4 short presses, OVER
// for five or more, LONG, XLONG) delivered as registered one-cycle pulses.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   btn_in     in  raw asynchronous button level, 1 = pressed
//   evt_valid  out one-cycle event pulse
//   evt_code   out event code (EVT_*), 0 when evt_valid is low
//   btn_held   out debounced button level
//
// state       | meaning
// ST_IDLE     | no gesture in progress
// ST_PRESS    | button held, hold_cnt counting
// ST_GAP      | released after a short press, waiting for another press
// ST_WAIT_REL | XLONG already reported, waiting for release
// ---------------------------------------------------------------------------
module btn_gesture_decoder
    import btn_gesture_pkg::*;
#(
    parameter int DEB_CYC   = 2,
    parameter int LONG_CYC  = 10,
    parameter int XLONG_CYC = 40,
    parameter int GAP_CYC   = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       btn_held
);

    localparam int HW = $clog2(XLONG_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [HW-1:0] HOLD_LONG  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_XLONG = HW'(XLONG_CYC);
    localparam logic [GW-1:0] GAP_END    = GW'(GAP_CYC);

    logic           w_db;
    gesture_state_t r_state;
    logic [HW-1:0]  r_hold_cnt;
    logic [GW-1:0]  r_gap_cnt;
    logic [2:0]     r_n_short;
    logic           r_evt_valid;
    logic [2:0]     r_evt_code;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .i_btn (btn_in),
        .o_db  (w_db)
    );

    // hold_cnt and gap_cnt both include the edge cycle that started them, so
    // a press of N debounced-high cycles ends with hold_cnt = N and the gap
    // expires after exactly GAP_CYC debounced-low cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_n_short   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= EVT_NONE;
        end else begin
            r_evt_valid <= 1'b0;
            r_evt_code  <= EVT_NONE;
            case (r_state)
                ST_IDLE: begin
                    if (w_db) begin
                        r_hold_cnt <= HW'(1);
                        r_state    <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (r_hold_cnt == HOLD_XLONG) begin
                        r_evt_valid <= 1'b1;
                        r_evt_code  <= EVT_XLONG;
                        r_n_short   <= '0;
                        r_state     <= ST_WAIT_REL;
                    end else if (!w_db) begin
                        if (r_hold_cnt < HOLD_LONG) begin
                            if (r_n_short < N_SHORT_MAX) begin
                                r_n_short <= r_n_short + 3'd1;
                            end
                            r_gap_cnt <= GW'(1);
                            r_state   <= ST_GAP;
                        end else begin
                            r_evt_valid <= 1'b1;
                            r_evt_code  <= EVT_LONG;
                            r_n_short   <= '0;
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_END) begin
                        r_evt_valid <= 1'b1;
                        r_evt_code  <= multi_code(r_n_short);
                        r_n_short   <= '0;
                        // A press landing on the expiry cycle starts a fresh
                        // sequence here instead of losing its first cycle.
                        if (w_db) begin
                            r_hold_cnt <= HW'(1);
                            r_state    <= ST_PRESS;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_db) begin
                        r_hold_cnt <= HW'(1);
                        r_state    <= ST_PRESS;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_db) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign btn_held  = w_db;

endmodule

// File: tb/tb_btn_gesture_decoder.sv
module tb_btn_gesture_decoder;

    localparam int DEB   = 2;
    localparam int LONG  = 10;
    localparam int XLONG = 40;
    localparam int GAP   = 12;
    localparam int DL    = 2 + DEB;   // btn_in edge to debounced edge

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_in;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       btn_held;

    int tests = 0;
    int fails = 0;

    bit stim[$];
    bit obs_v[$];
    int obs_c[$];
    bit obs_h[$];
    int ev_cyc[$];
    int ev_code[$];
    bit exp_db[$];
    bit exp_v[$];
    int exp_c[$];

    always #5 clk = ~clk;

    btn_gesture_decoder #(
        .DEB_CYC   (DEB),
        .LONG_CYC  (LONG),
        .XLONG_CYC (XLONG),
        .GAP_CYC   (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .btn_held  (btn_held)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_lvl(input bit lvl, input int n);
        repeat (n) stim.push_back(lvl);
    endtask

    // Cycle t: outputs sampled 1 ns after the edge, then btn_in takes stim[t].
    task automatic run_stim();
        obs_v.delete(); obs_c.delete(); obs_h.delete();
        ev_cyc.delete(); ev_code.delete();
        for (int t = 0; t < stim.size(); t++) begin
            @(posedge clk);
            #1;
            obs_v.push_back(evt_valid);
            obs_c.push_back(int'(evt_code));
            obs_h.push_back(btn_held);
            if (evt_valid) begin
                ev_cyc.push_back(t);
                ev_code.push_back(int'(evt_code));
            end
            btn_in = stim[t];
        end
    endtask

    function automatic int first_code();
        return (ev_code.size() > 0) ? ev_code[0] : -1;
    endfunction

    function automatic int first_cyc();
        return (ev_cyc.size() > 0) ? ev_cyc[0] : -1;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit s_at(input int idx);
        return (idx >= 2 && idx - 2 < stim.size()) ? stim[idx-2] : 1'b0;
    endfunction

    task automatic post(input int idx, input int code);
        if (idx < exp_v.size()) begin
            exp_v[idx] = 1'b1;
            exp_c[idx] = code;
        end
    endtask

    // Debounced level from "DEB identical samples that disagree", then the
    // gesture rules applied to the lengths of the debounced high/low runs.
    task automatic build_model();
        int L, u, n, a, h, f, g;
        bit v, all;
        L = stim.size();
        exp_db.delete(); exp_v.delete(); exp_c.delete();
        for (int i = 0; i < L; i++) begin
            exp_v.push_back(1'b0);
            exp_c.push_back(0);
        end
        exp_db.push_back(1'b0);
        for (int i = 0; i < L - 1; i++) begin
            v   = s_at(i);
            all = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (i - j < 0 || s_at(i - j) != v) all = 1'b0;
            exp_db.push_back((all && v != exp_db[i]) ? v : exp_db[i]);
        end
        u = 0;
        n = 0;
        while (u < L) begin
            if (exp_db[u] && (u == 0 || !exp_db[u-1])) begin
                a = u;
                h = 0;
                while (a + h < L && exp_db[a+h]) h++;
                f = a + h;
                if (h >= XLONG) begin
                    post(a + XLONG + 1, 6);
                    n = 0;
                end else if (f < L && h >= LONG) begin
                    post(f + 1, 5);
                    n = 0;
                end else if (f < L) begin
                    n = (n < 5) ? n + 1 : 5;
                    g = 0;
                    while (f + g < L && !exp_db[f+g]) g++;
                    if (g >= GAP) begin
                        post(f + GAP + 1, (n == 5) ? 7 : n);
                        n = 0;
                    end
                end
                u = (f > u) ? f : u + 1;
            end else begin
                u++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_evt_valid: got %b, expected 0", evt_valid); end
        tests++;
        if (evt_code !== 3'd0) begin fails++; $display("FAIL reset_evt_code: got %0d, expected 0", evt_code); end
        tests++;
        if (btn_held !== 1'b0) begin fails++; $display("FAIL reset_btn_held: got %b, expected 0", btn_held); end
    endtask

    task automatic test_short();
        int exp_cyc;
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, 5); add_lvl(0, 30);
        run_stim();
        exp_cyc = 2 + DL + 5 + GAP + 1;
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL short_count: got %0d events, expected 1", ev_cyc.size()); end
        tests++;
        if (first_code() !== 1) begin fails++; $display("FAIL short_code: got %0d, expected 1", first_code()); end
        tests++;
        if (first_cyc() !== exp_cyc) begin fails++; $display("FAIL short_latency: got cycle %0d, expected %0d", first_cyc(), exp_cyc); end
    endtask

    task automatic test_multi(input int k, input int code);
        int exp_cyc;
        apply_reset();
        stim.delete();
        add_lvl(0, 2);
        for (int i = 0; i < k; i++) begin
            add_lvl(1, 5);
            add_lvl(0, (i == k - 1) ? 30 : 5);
        end
        run_stim();
        exp_cyc = 2 + (k - 1) * 10 + DL + 5 + GAP + 1;
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL multi%0d_count: got %0d events, expected 1", k, ev_cyc.size()); end
        tests++;
        if (first_code() !== code) begin fails++; $display("FAIL multi%0d_code: got %0d, expected %0d", k, first_code(), code); end
        tests++;
        if (first_cyc() !== exp_cyc) begin fails++; $display("FAIL multi%0d_latency: got cycle %0d, expected %0d", k, first_cyc(), exp_cyc); end
    endtask

    task automatic test_long(input int p, input int code);
        int fall, exp_cyc;
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, p); add_lvl(0, 30);
        run_stim();
        fall    = 2 + DL + p;
        exp_cyc = (code == 5) ? fall + 1 : fall + GAP + 1;
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL hold%0d_count: got %0d events, expected 1", p, ev_cyc.size()); end
        tests++;
        if (first_code() !== code) begin fails++; $display("FAIL hold%0d_code: got %0d, expected %0d", p, first_code(), code); end
        tests++;
        if (first_cyc() !== exp_cyc) begin fails++; $display("FAIL hold%0d_latency: got cycle %0d, expected %0d", p, first_cyc(), exp_cyc); end
    endtask

    task automatic test_xlong();
        int exp_cyc;
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, 50); add_lvl(0, 30);
        run_stim();
        exp_cyc = 2 + DL + XLONG + 1;
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL xlong_count: got %0d events, expected 1", ev_cyc.size()); end
        tests++;
        if (first_code() !== 6) begin fails++; $display("FAIL xlong_code: got %0d, expected 6", first_code()); end
        tests++;
        if (first_cyc() !== exp_cyc) begin fails++; $display("FAIL xlong_latency: got cycle %0d, expected %0d", first_cyc(), exp_cyc); end
        tests++;
        if (obs_h[exp_cyc] !== 1'b1) begin fails++; $display("FAIL xlong_still_held: got btn_held %b, expected 1", obs_h[exp_cyc]); end
    endtask

    task automatic test_mixed();
        int exp_cyc, held_cnt;
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, 5); add_lvl(0, 5); add_lvl(1, 5); add_lvl(0, 5);
        add_lvl(1, 11); add_lvl(0, 30);
        run_stim();
        exp_cyc = 22 + DL + 11 + 1;
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL mixed_count: got %0d events, expected 1", ev_cyc.size()); end
        tests++;
        if (first_code() !== 5) begin fails++; $display("FAIL mixed_code: got %0d, expected 5", first_code()); end
        tests++;
        if (first_cyc() !== exp_cyc) begin fails++; $display("FAIL mixed_latency: got cycle %0d, expected %0d", first_cyc(), exp_cyc); end
        apply_reset();
        stim.delete();
        add_lvl(0, 5); add_lvl(1, 1); add_lvl(0, 30);
        run_stim();
        held_cnt = 0;
        foreach (obs_h[t]) if (obs_h[t]) held_cnt++;
        tests++;
        if (held_cnt !== 0) begin fails++; $display("FAIL glitch_held: got %0d held cycles, expected 0", held_cnt); end
        tests++;
        if (ev_cyc.size() !== 0) begin fails++; $display("FAIL glitch_events: got %0d events, expected 0", ev_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        // Double press, reset while waiting out the gap.
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, 5); add_lvl(0, 5); add_lvl(1, 5); add_lvl(0, 8);
        run_stim();
        tests++;
        if (ev_cyc.size() !== 0) begin fails++; $display("FAIL rstgap_pre_events: got %0d events, expected 0", ev_cyc.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({evt_valid, evt_code, btn_held} !== 5'b0) begin
            fails++;
            $display("FAIL rstgap_outputs: got valid=%b code=%0d held=%b, expected all 0", evt_valid, evt_code, btn_held);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        add_lvl(0, 30);
        run_stim();
        tests++;
        if (ev_cyc.size() !== 0) begin fails++; $display("FAIL rstgap_post_events: got %0d events, expected 0", ev_cyc.size()); end

        // Reset while held; the remaining hold must count from scratch.
        apply_reset();
        stim.delete();
        add_lvl(0, 2); add_lvl(1, 8);
        run_stim();
        tests++;
        if (obs_h[obs_h.size()-1] !== 1'b1) begin fails++; $display("FAIL rsthold_pre_held: got %b, expected 1", obs_h[obs_h.size()-1]); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (btn_held !== 1'b0) begin fails++; $display("FAIL rsthold_held: got %b, expected 0", btn_held); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        add_lvl(1, 5); add_lvl(0, 30);
        run_stim();
        tests++;
        if (ev_cyc.size() !== 1) begin fails++; $display("FAIL rsthold_count: got %0d events, expected 1", ev_cyc.size()); end
        tests++;
        if (first_code() !== 1) begin fails++; $display("FAIL rsthold_code: got %0d, expected 1", first_code()); end
    endtask

    task automatic test_random(input int runs);
        int r, len;
        for (int k = 0; k < runs; k++) begin
            apply_reset();
            stim.delete();
            add_lvl(0, 2);
            while (stim.size() < 400) begin
                r = $urandom_range(0, 9);
                if (r == 0)      len = 1;
                else if (r < 5)  len = $urandom_range(2, 11);
                else if (r < 8)  len = $urandom_range(9, 42);
                else             len = $urandom_range(38, 55);
                add_lvl(1, len);
                r = $urandom_range(0, 3);
                len = (r == 0) ? $urandom_range(11, 13) : $urandom_range(1, 18);
                add_lvl(0, len);
            end
            add_lvl(0, 60);
            run_stim();
            build_model();
            for (int t = 0; t < stim.size(); t++) begin
                tests++;
                if (obs_v[t] !== exp_v[t] || obs_c[t] !== exp_c[t]) begin
                    fails++;
                    $display("FAIL rand_evt run %0d cyc %0d: got valid=%b code=%0d, expected valid=%b code=%0d",
                             k, t, obs_v[t], obs_c[t], exp_v[t], exp_c[t]);
                end
                tests++;
                if (obs_h[t] !== exp_db[t]) begin
                    fails++;
                    $display("FAIL rand_held run %0d cyc %0d: got %b, expected %b", k, t, obs_h[t], exp_db[t]);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;
        test_reset();
        test_short();
        test_multi(3, 3);
        test_multi(4, 4);
        test_multi(6, 7);
        test_long(11, 5);
        test_long(10, 5);
        test_long(9, 1);
        test_xlong();
        test_mixed();
        test_reset_mid();
        test_random(6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
